adc_scan_sequencer: RTL and testbench
=====================================

// Module: adc_scan_sequencer
// PURPOSE
//   Multi-channel scan scheduler in front of the SAR ADC controller. Powers the ADC only
//   while a scan is running. Steps an analog mux over the enabled channels and waits for
//   mux settling. Issues the conversion Start, captures each 8-bit result on the done
//   strobe, and hands results downstream over a valid/ready port. Between scans the ADC
//   sleeps for a programmable interval, which is the low-power duty-cycling point.
// PARAMETERS
//   NCH        4   number of analog channels
//   DW         8   ADC result width
//   WAKE_CYC   4   cycles from adc_pwr_en rise to first mux settle
//   SETTLE_CYC 2   cycles of mux settling before each Start
//   TIMEOUT    32  max cycles in CONVERT waiting for adc_done
//   IW         16  width of interval
//   CW         $clog2(NCH), localparam
// PORTS
//   clk          in   1    system clock, rising edge
//   clr          in   1    asynchronous reset, active-high
//   enable       in   1    scanning enabled
//   chan_mask    in   NCH  channels to convert; sampled at scan start
//   interval     in   IW   sleep cycles between scans; 0 = single-shot
//   adc_pwr_en   out  1    ADC/comparator power enable
//   mux_sel      out  CW   analog mux channel select
//   adc_start    out  1    conversion request to ADC controller (level)
//   adc_done     in   1    one-cycle conversion-complete strobe (controller LoadReg)
//   adc_data     in   DW   conversion result; valid while adc_done=1
//   res_valid    out  1    result available
//   res_ready    in   1    downstream accepts result
//   res_chan     out  CW   channel of res_data
//   res_data     out  DW   captured result
//   timeout_err  out  1    sticky: a conversion timed out
//   busy         out  1    state != IDLE
// BEHAVIOUR
//   - Reset (clr=1, async): state IDLE; all outputs 0; counters 0; mask register 0.
//     Asserting clr mid-operation drops adc_start and adc_pwr_en immediately.
//   - States: IDLE, POWERUP, SETTLE, CONVERT, STORE, NEXT, SLEEP, DONE.
//   - IDLE: enable=1 and chan_mask!=0 -> POWERUP. On this transition:
//     - latch chan_mask;
//     - clear timeout_err;
//     - set mux_sel to the lowest set bit.
//     With enable=1 and chan_mask=0, the block stays in IDLE.
//   - POWERUP: adc_pwr_en=1; after WAKE_CYC cycles -> SETTLE.
//   - SETTLE: mux_sel stable; after SETTLE_CYC cycles -> CONVERT.
//   - Latency: enable sampled at edge k -> adc_pwr_en=1 from cycle k+1 -> adc_start=1
//     from cycle k+1+WAKE_CYC+SETTLE_CYC (k+7 with defaults).
//   - CONVERT: adc_start held at 1 until adc_done is sampled.
//     - On adc_done: res_data<=adc_data, res_chan<=mux_sel, adc_start<=0, -> STORE.
//       res_valid=1 on the next cycle.
//     - If TIMEOUT cycles pass without adc_done: timeout_err<=1, adc_start<=0, no result
//       is produced, -> NEXT.
//   - adc_done is ignored in every state other than CONVERT.
//   - STORE: res_valid=1; res_chan and res_data stay stable until res_valid&&res_ready,
//     then res_valid<=0, -> NEXT. res_ready=1 in the first STORE cycle costs one cycle.
//   - NEXT (one cycle):
//     - if enable=0 -> IDLE (adc_pwr_en<=0);
//     - else if a latched mask bit above mux_sel is set -> mux_sel<=that index, -> SETTLE;
//     - else interval==0 -> DONE;
//     - else -> SLEEP.
//   - SLEEP: adc_pwr_en=0. After interval cycles -> POWERUP, re-latching chan_mask; if the
//     new mask is 0, go to IDLE instead. enable=0 in SLEEP -> IDLE next cycle.
//   - DONE: adc_pwr_en=0; wait for enable=0 -> IDLE. A single-shot restart needs an enable
//     low-then-high.
//   - enable falling mid-scan: the current channel completes (including the STORE
//     handshake), then NEXT -> IDLE.
//   - Changes to chan_mask or interval mid-scan have no effect until the next latch.
//   - adc_pwr_en=1 exactly in POWERUP, SETTLE, CONVERT, STORE, NEXT.
//   - mux_sel never changes while adc_start=1.
// TESTING
//   1 mask=4'b0101, interval=0, ADC model: adc_done 3 cycles after Start, data A5 then 3C,
//     res_ready=1 -> results (0,A5) then (2,3C); DONE; adc_pwr_en=0; busy=1 until enable=0.
//   2 Backpressure: res_ready=0 for 10 cycles in STORE -> res_valid held, res_data stable,
//     no adc_start; first handshake advances to the next channel.
//   3 Timeout: mask=4'b0011, adc_done never on ch0 -> adc_start drops after 32 cycles,
//     timeout_err=1, no result for ch0, ch1 converts normally.
//   4 interval=20, mask=4'b0001 -> adc_pwr_en low exactly 20 cycles between scans; 3
//     consecutive results on ch0.
//   5 clr pulsed during CONVERT -> adc_start, adc_pwr_en, res_valid and busy go 0 the same
//     cycle; after release the block stays IDLE until enable is seen.
//   6 enable=1 with mask=0 -> stays IDLE; enable dropped during ch1 of 4'b1111 -> ch1
//     result delivered, then IDLE, no ch2 Start.

Source files
------------

// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
//   Scan scheduler in front of the SAR ADC controller. Powers the ADC only while
//   a scan runs, walks the analog mux over the latched channel mask, waits for
//   wake-up and mux settling, requests conversions, captures results and hands
//   them downstream over valid/ready. Between scans the ADC sleeps for a
//   programmable interval (0 = single-shot).
// Ports
//   clk, clr           clock (rising edge), async active-high reset
//   enable             scanning enabled
//   chan_mask          channels to convert, latched at scan start
//   interval           sleep cycles between scans, latched at scan start
//   adc_pwr_en         ADC/comparator power enable
//   mux_sel            analog mux channel select
//   adc_start          conversion request (level)
//   adc_done, adc_data conversion-complete strobe and result
//   res_valid/ready    downstream result handshake; res_chan/res_data payload
//   timeout_err        sticky, a conversion timed out during this scan run
//   busy               not idle
module adc_scan_sequencer #(
  parameter int NCH        = 4,
  parameter int DW         = 8,
  parameter int WAKE_CYC   = 4,
  parameter int SETTLE_CYC = 2,
  parameter int TIMEOUT    = 32,
  parameter int IW         = 16,
  localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           enable,
  input  logic [NCH-1:0] chan_mask,
  input  logic [IW-1:0]  interval,
  output logic           adc_pwr_en,
  output logic [CW-1:0]  mux_sel,
  output logic           adc_start,
  input  logic           adc_done,
  input  logic [DW-1:0]  adc_data,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [CW-1:0]  res_chan,
  output logic [DW-1:0]  res_data,
  output logic           timeout_err,
  output logic           busy
);
  // one shared counter times wake-up, settling, conversion timeout and sleep
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int CNTW = (IW > TW) ? IW : TW;

  typedef enum logic [2:0] {
    IDLE, POWERUP, SETTLE, CONVERT, STORE, NEXT, SLEEP, DONE
  } state_t;

  state_t          state, state_d;
  logic [CNTW-1:0] cnt;
  logic [NCH-1:0]  mask_q;
  logic [IW-1:0]   ival_q;

  logic            latch, adv, cap, tmo, tmo_clr, has_above;
  logic [CW-1:0]   lowest, above;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    latch     = 1'b0;
    adv       = 1'b0;
    cap       = 1'b0;
    tmo       = 1'b0;
    tmo_clr   = 1'b0;
    lowest    = '0;
    above     = '0;
    has_above = 1'b0;

    // descending scans leave the lowest qualifying index as the final assignment
    for (int i = NCH - 1; i >= 0; i--) begin
      if (chan_mask[i]) lowest = CW'(i);
      if (mask_q[i] && (i > int'(mux_sel))) begin
        above     = CW'(i);
        has_above = 1'b1;
      end
    end

    unique case (state)
      IDLE:
        if (enable && (|chan_mask)) begin
          state_d = POWERUP;
          latch   = 1'b1;
          tmo_clr = 1'b1;
        end
      POWERUP:
        if (cnt == CNTW'(WAKE_CYC - 1)) state_d = SETTLE;
      SETTLE:
        if (cnt == CNTW'(SETTLE_CYC - 1)) state_d = CONVERT;
      CONVERT:
        if (adc_done) begin
          state_d = STORE;
          cap     = 1'b1;
        end else if (cnt == CNTW'(TIMEOUT - 1)) begin
          state_d = NEXT;
          tmo     = 1'b1;
        end
      STORE:
        if (res_ready) state_d = NEXT;
      NEXT:
        if (!enable)            state_d = IDLE;
        else if (has_above) begin
          state_d = SETTLE;
          adv     = 1'b1;
        end
        else if (ival_q == '0)  state_d = DONE;
        else                    state_d = SLEEP;
      SLEEP:
        if (!enable) state_d = IDLE;
        else if (cnt == CNTW'(ival_q - 1'b1)) begin
          // periodic rescan picks up whatever mask is present now
          if (|chan_mask) begin
            state_d = POWERUP;
            latch   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      DONE:
        if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // decoded from the state register so clr kills them without waiting for a clock
  always_comb begin
    adc_pwr_en = (state == POWERUP) || (state == SETTLE) || (state == CONVERT) ||
                 (state == STORE)   || (state == NEXT);
    adc_start  = (state == CONVERT);
    res_valid  = (state == STORE);
    busy       = (state != IDLE);
  end

  // mux_sel only moves on latch (IDLE/SLEEP) or advance (NEXT), never under adc_start
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt         <= '0;
      mask_q      <= '0;
      ival_q      <= '0;
      mux_sel     <= '0;
      res_chan    <= '0;
      res_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt <= (state_d != state) ? '0 : cnt + 1'b1;
      if (latch) begin
        mask_q  <= chan_mask;
        ival_q  <= interval;
        mux_sel <= lowest;
      end else if (adv) begin
        mux_sel <= above;
      end
      if (tmo_clr)  timeout_err <= 1'b0;
      else if (tmo) timeout_err <= 1'b1;
      if (cap) begin
        res_data <= adc_data;
        res_chan <= mux_sel;
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer. A small ADC responder raises adc_done
// three cycles after adc_start goes high, returning bytes from a queue.
module tb_adc_scan_sequencer;
  logic        clk = 1'b0, clr = 1'b1, enable = 1'b0;
  logic [3:0]  chan_mask = '0;
  logic [15:0] interval = '0;
  logic        adc_pwr_en, adc_start, res_valid, timeout_err, busy;
  logic [1:0]  mux_sel, res_chan;
  logic        adc_done = 1'b0;
  logic [7:0]  adc_data = '0;
  logic        res_ready = 1'b1;
  logic [7:0]  res_data;

  int   checks = 0, errors = 0;
  bit   adc_respond = 1'b1;
  int   sc = 0;
  logic [7:0] data_q[$];

  always #5 clk = ~clk;

  adc_scan_sequencer dut (
    .clk(clk), .clr(clr), .enable(enable), .chan_mask(chan_mask), .interval(interval),
    .adc_pwr_en(adc_pwr_en), .mux_sel(mux_sel), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data), .res_valid(res_valid),
    .res_ready(res_ready), .res_chan(res_chan), .res_data(res_data),
    .timeout_err(timeout_err), .busy(busy)
  );

  // ADC responder
  always begin
    @(posedge clk); #1;
    adc_done = 1'b0;
    if (adc_start && adc_respond) begin
      sc++;
      if (sc == 3) begin
        adc_done = 1'b1;
        if (data_q.size() > 0) adc_data = data_q.pop_front();
        else                   adc_data = 8'hEE;
        sc = 0;
      end
    end else begin
      sc = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag, input int maxc);
    int i = 0;
    do begin @(negedge clk); i++; end while (!res_valid && i < maxc);
    chk({tag, "_arrive"}, 32'(res_valid), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int maxc);
    int i = 0;
    do begin @(negedge clk); i++; end while (!adc_start && i < maxc);
    chk({tag, "_start"}, 32'(adc_start), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int i = 0;
    do begin @(negedge clk); i++; end while (busy && i < maxc);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n, nres, ngap, run;
    bit seen_hi, ok, st;
    int gaps[2];
    logic [7:0] exp_d;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pwr", 32'(adc_pwr_en), 0);
    chk("rst_start", 32'(adc_start), 0);
    chk("rst_outs", {res_valid, busy, timeout_err, mux_sel, res_chan, res_data}, 0);
    clr = 1'b0;
    @(negedge clk);

    // 1: mask 0101 single-shot, exact start latency
    chan_mask = 4'b0101; interval = 0; res_ready = 1; adc_respond = 1;
    data_q = '{8'hA5, 8'h3C};
    enable = 1;
    @(negedge clk);
    chk("t1_pwr_k1", 32'(adc_pwr_en), 1);
    chk("t1_mux_low", 32'(mux_sel), 0);
    repeat (5) @(negedge clk);
    chk("t1_start_k6", 32'(adc_start), 0);
    @(negedge clk);
    chk("t1_start_k7", 32'(adc_start), 1);
    wait_valid("t1_r0", 20);
    chk("t1_r0", {res_chan, res_data}, {2'd0, 8'hA5});
    chan_mask = 4'b1000;  // must not affect the scan in flight
    wait_valid("t1_r1", 20);
    chk("t1_r1", {res_chan, res_data}, {2'd2, 8'h3C});
    repeat (2) @(negedge clk);
    chk("t1_done_pwr", 32'(adc_pwr_en), 0);
    repeat (5) @(negedge clk);
    chk("t1_done_busy", {busy, adc_start}, {1'b1, 1'b0});
    enable = 0;
    @(negedge clk);
    chk("t1_idle", 32'(busy), 0);

    // 2: backpressure
    chan_mask = 4'b0011; res_ready = 0; data_q = '{8'h11, 8'h22};
    enable = 1;
    wait_valid("t2_r0", 20);
    chk("t2_r0", {res_chan, res_data}, {2'd0, 8'h11});
    ok = 1;
    repeat (10) begin
      @(negedge clk);
      if (!(res_valid === 1'b1 && res_data === 8'h11 && res_chan === 2'd0 && adc_start === 1'b0))
        ok = 0;
    end
    chk("t2_hold", 32'(ok), 1);
    res_ready = 1;
    @(negedge clk);
    chk("t2_hs_drop", 32'(res_valid), 0);
    @(negedge clk);
    chk("t2_adv_mux", 32'(mux_sel), 1);
    wait_valid("t2_r1", 20);
    chk("t2_r1", {res_chan, res_data}, {2'd1, 8'h22});
    enable = 0;
    wait_idle("t2", 5);

    // 3: timeout on ch0, ch1 converts
    chan_mask = 4'b0011; adc_respond = 0; data_q = '{8'h33};
    enable = 1;
    wait_start("t3", 20);
    n = 1;
    do begin @(negedge clk); if (adc_start) n++; end while (adc_start && n < 100);
    chk("t3_tmo_len", 32'(n), 32);
    chk("t3_err", {timeout_err, res_valid}, {1'b1, 1'b0});
    adc_respond = 1;
    wait_valid("t3_r1", 20);
    chk("t3_r1", {res_chan, res_data}, {2'd1, 8'h33});
    chk("t3_sticky", 32'(timeout_err), 1);
    enable = 0;
    wait_idle("t3", 5);

    // 4: periodic scan with interval 20
    chan_mask = 4'b0001; interval = 20; data_q = '{8'h41, 8'h42, 8'h43};
    enable = 1;
    @(negedge clk);
    chk("t4_err_clr", 32'(timeout_err), 0);
    nres = 0; ngap = 0; run = 0; seen_hi = 1; ok = 1;
    for (int c = 0; c < 400 && nres < 3; c++) begin
      @(negedge clk);
      if (adc_pwr_en) begin
        if (run > 0) begin
          if (ngap < 2) gaps[ngap] = run;
          ngap++;
        end
        run = 0;
      end else if (seen_hi) begin
        run++;
      end
      if (res_valid && res_ready) begin
        exp_d = 8'(8'h41 + nres);
        if (res_chan !== 2'd0 || res_data !== exp_d) ok = 0;
        nres++;
      end
    end
    chk("t4_nres", 32'(nres), 3);
    chk("t4_ngap", 32'(ngap), 2);
    chk("t4_gap0", 32'(gaps[0]), 20);
    chk("t4_gap1", 32'(gaps[1]), 20);
    chk("t4_data", 32'(ok), 1);
    enable = 0;
    wait_idle("t4", 30);

    // 5: clr during CONVERT
    interval = 0; chan_mask = 4'b0001; adc_respond = 0;
    enable = 1;
    wait_start("t5", 20);
    repeat (3) @(negedge clk);
    clr = 1; #1;
    chk("t5_clr_now", {adc_start, adc_pwr_en, res_valid, busy}, 4'b0000);
    enable = 0;
    @(negedge clk);
    clr = 0;
    repeat (5) @(negedge clk);
    chk("t5_stay_idle", {busy, adc_pwr_en}, 2'b00);
    enable = 1;
    @(negedge clk);
    chk("t5_restart", 32'(adc_pwr_en), 1);
    clr = 1; enable = 0;
    @(negedge clk);
    clr = 0;

    // 6: empty mask, then enable drop during ch1
    enable = 1; chan_mask = 4'b0000;
    repeat (5) @(negedge clk);
    chk("t6_mask0", {busy, adc_pwr_en}, 2'b00);
    adc_respond = 1; data_q = '{8'h61, 8'h62};
    chan_mask = 4'b1111;
    wait_valid("t6_r0", 20);
    chk("t6_r0", {res_chan, res_data}, {2'd0, 8'h61});
    wait_start("t6_c1", 20);
    enable = 0;
    wait_valid("t6_r1", 20);
    chk("t6_r1", {res_chan, res_data}, {2'd1, 8'h62});
    st = 0;
    repeat (40) begin
      @(negedge clk);
      if (adc_start) st = 1;
    end
    chk("t6_no_ch2", 32'(st), 0);
    chk("t6_idle", {busy, mux_sel}, {1'b0, 2'd1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
